// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data widths, fetch FSM states, next-PC
// selector and the opcode constants that main_decoder also decodes.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // A fetch target must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register and next-PC mux (hold / pc+4 / redirect target).
// FETCH_MISALIGN_TRAP_EN: when defined, a misaligned redirect target is kept
// as-is and flagged on o_misaligned; otherwise its low two bits are cleared
// and o_misaligned is tied low.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         i_sel,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target     = i_redirect_pc;
  assign o_misaligned = is_misaligned(i_redirect_pc);
`else
  assign w_target     = i_redirect_pc & ~XLEN'(2'b11);
  assign o_misaligned = 1'b0;
`endif

  // Wraps modulo 2^XLEN; no overflow is reported.
  assign o_pc_plus4 = r_pc + PC_STEP;
  assign o_pc       = r_pc;

  // PC register: load the selected next-PC source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      case (i_sel)
        PC_INC:   r_pc <= o_pc_plus4;
        PC_REDIR: r_pc <= w_target;
        PC_HOLD:  r_pc <= r_pc;
        default:  r_pc <= r_pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one-outstanding imem requests, instruction
// register held until decode accepts it, redirects from execute.
// FETCH_MISALIGN_TRAP_EN: when defined, a misaligned redirect halts fetch
// with a sticky fetch_err until reset; otherwise fetch_err stays 0.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  fetch_state_t    r_state;
  logic            r_req_valid;
  logic            r_instr_valid;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] r_instr_pc_plus4;
  logic            r_fetch_err;

  pc_sel_t         w_pc_sel;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_misaligned;
  logic            w_req_hs;
  logic            w_trap;

  assign w_req_hs = r_req_valid & imem_req_ready;
  // w_misaligned is constant 0 when the trap is not built in.
  assign w_trap   = redirect_valid & w_misaligned & (r_state != S_HALT);

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sel         (w_pc_sel),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc),
    .o_pc_plus4    (w_pc_plus4),
    .o_misaligned  (w_misaligned)
  );

  // Next-PC selection: redirect wins, pc+4 on an accepted response, else hold.
  always_comb begin
    w_pc_sel = PC_HOLD;
    if (r_state == S_HALT) begin
      w_pc_sel = PC_HOLD;
    end else if (redirect_valid) begin
      w_pc_sel = PC_REDIR;
    end else if ((r_state == S_WAIT) && imem_rsp_valid) begin
      w_pc_sel = PC_INC;
    end else begin
      w_pc_sel = PC_HOLD;
    end
  end

  // Fetch FSM with registered request valid and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_REQ;
      r_req_valid      <= 1'b0;
      r_instr_valid    <= 1'b0;
      r_instr          <= {ILEN{1'b0}};
      r_instr_pc       <= {XLEN{1'b0}};
      r_instr_pc_plus4 <= {XLEN{1'b0}};
      r_fetch_err      <= 1'b0;
    end else if (w_trap) begin
      r_state       <= S_HALT;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b1;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            // An accepted request is now stale: its response must be dropped.
            r_state     <= w_req_hs ? S_DROP : S_REQ;
            r_req_valid <= ~w_req_hs;
          end else if (w_req_hs) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_state     <= imem_rsp_valid ? S_REQ : S_DROP;
            r_req_valid <= imem_rsp_valid;
          end else if (imem_rsp_valid) begin
            r_state          <= S_HOLD;
            r_instr          <= imem_rsp_data;
            r_instr_pc       <= w_pc;
            r_instr_pc_plus4 <= w_pc_plus4;
            r_instr_valid    <= 1'b1;
          end else begin
            r_req_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (redirect_valid || instr_ready) begin
            r_state       <= S_REQ;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b1;
          end else begin
            r_instr_valid <= 1'b1;
          end
        end
        S_DROP: begin
          // A redirect here only moves the PC; the outstanding response is
          // still the one being discarded.
          if (imem_rsp_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end else begin
            r_req_valid <= 1'b0;
          end
        end
        S_HALT: begin
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fetch_err   <= 1'b1;
        end
        default: begin
          r_state       <= S_REQ;
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = w_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc_plus4;
  assign fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected fetches and
// a configurable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          lat = 1;
  int          pend = 0;
  logic [31:0] pend_addr = 32'd0;
  logic        got = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory model, then scoreboard check on a new instruction.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    logic        prev_iv;
    logic [31:0] e;
    hs      = imem_req_valid & imem_req_ready;
    hs_addr = imem_addr;
    prev_iv = instr_valid;
    @(posedge clk);
    #1;
    if (hs) begin
      pend      = lat;
      pend_addr = hs_addr;
      sb.push_back(hs_addr);
    end
    imem_rsp_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end
    end
    if (instr_valid && !prev_iv) begin
      got = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_unexpected_instr", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", instr, mem_word(e));
        chk("sb_instr_pc", instr_pc, e);
        chk("sb_instr_pc_plus4", instr_pc_plus4, e + 32'd4);
      end
    end
  endtask

  task automatic redirect_tick(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, imem_req_valid, 32'd1);
    chk(tag, imem_addr, exp);
  endtask

  task automatic wait_instr(input string tag);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) tick();
    chk(tag, got, 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_instr_valid", instr_valid, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_pc_plus4", instr_pc_plus4, 32'd0);
    chk("rst_fetch_err", fetch_err, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;

    // 1: first fetch from address 0
    wait_req("t1_req_addr", 32'h0000_0000);
    wait_instr("t1_instr_arrived");

    // 2: decode stalls for 5 cycles, then accepts
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", instr_valid, 32'd1);
      chk("t2_hold_instr", instr, 32'h0000_0013);
      chk("t2_hold_pc", instr_pc, 32'd0);
      chk("t2_no_req", imem_req_valid, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_req_after_ready", imem_req_valid, 32'd1);
    chk("t2_req_addr", imem_addr, 32'h0000_0004);
    chk("t2_valid_fell", instr_valid, 32'd0);

    // 3: redirect in S_WAIT, response two cycles after the request
    lat = 2;
    tick();
    chk("t3_in_wait", imem_req_valid, 32'd0);
    redirect_tick(32'h0000_0100);
    sb.delete();
    lat = 1;
    wait_req("t3_req_addr", 32'h0000_0100);
    chk("t3_no_instr", instr_valid, 32'd0);

    // 4: redirect in S_HOLD with instr_ready high squashes the instruction
    wait_instr("t4_instr_arrived");
    redirect_tick(32'h0000_0040);
    chk("t4_valid_fell", instr_valid, 32'd0);
    chk("t4_req_valid", imem_req_valid, 32'd1);
    chk("t4_req_addr", imem_addr, 32'h0000_0040);

    // 5: redirect on a request handshake (stale), then fetch at top of memory
    redirect_tick(32'hFFFF_FFFC);
    sb.delete();
    chk("t5_drop_no_req", imem_req_valid, 32'd0);
    wait_req("t5_req_top", 32'hFFFF_FFFC);
    wait_instr("t5_instr_arrived");
    wait_req("t5_wrap_addr", 32'h0000_0000);

    // Redirect in S_WAIT coinciding with the response
    tick();
    redirect_tick(32'h0000_0200);
    sb.delete();
    chk("t7_no_instr", instr_valid, 32'd0);
    chk("t7_req_valid", imem_req_valid, 32'd1);
    chk("t7_req_addr", imem_addr, 32'h0000_0200);

    // Address stays put while memory is not ready
    imem_req_ready = 1'b0;
    tick();
    tick();
    chk("t8_req_held", imem_req_valid, 32'd1);
    chk("t8_addr_stable", imem_addr, 32'h0000_0200);

    // 6: misaligned redirect target
    redirect_tick(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_fetch_err", fetch_err, 32'd1);
    chk("t6_halt_no_req", imem_req_valid, 32'd0);
    chk("t6_halt_no_instr", instr_valid, 32'd0);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_still_no_req", imem_req_valid, 32'd0);
    chk("t6_err_sticky", fetch_err, 32'd1);
    chk("t6_pc_records", imem_addr, 32'h0000_0102);
    rst_n = 1'b0;
    #1;
    chk("t6_err_cleared", fetch_err, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_req("t6_req_after_reset", 32'h0000_0000);
`else
    chk("t6_no_err", fetch_err, 32'd0);
    chk("t6_req_valid", imem_req_valid, 32'd1);
    chk("t6_req_addr", imem_addr, 32'h0000_0100);
    imem_req_ready = 1'b1;
`endif

    // Reset asserted while waiting; late response after release is ignored
    lat = 2;
    tick();
    chk("rw_in_wait", imem_req_valid, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_req_valid", imem_req_valid, 32'd0);
    chk("rw_instr_valid", instr_valid, 32'd0);
    chk("rw_addr", imem_addr, 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_late_rsp_ignored", instr_valid, 32'd0);
    chk("rw_req_valid_after", imem_req_valid, 32'd1);
    chk("rw_req_addr_after", imem_addr, 32'd0);
    lat = 1;
    wait_instr("rw_fetch_resumes");
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
